stepper_seq_driver: RTL and testbench

- Parametrised successor to the single-speed H-bridge stepper driver.
- Accepts move commands (step count, direction, full/half-step mode, step-rate divider) over a valid/ready handshake and sequences the 4-bit H-bridge phase outputs at the programmed rate.
- Signals completion, supports abort, and selects hold (energised) or coast at idle.
- Sits between the MSS/APB command registers and the H-bridge pins.

---
 rtl/stepper_seq_driver.sv | 179 +++++++++++++++++
 tb/tb_stepper_seq_driver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_seq_driver.sv
// stepper_seq_driver
//   Sequences the 4-bit H-bridge phase drive for a stepper motor. Accepts a
//   move command (step count, direction, full/half-step mode, step-rate
//   divider) over a valid/ready handshake and emits one phase update per
//   divider+1 clock cycles until the count is exhausted or the move is
//   aborted. At idle the last phase is held (IDLE_HOLD=1) or the bridge
//   coasts with all outputs low (IDLE_HOLD=0).
//
// Ports
//   clk         system clock
//   PRESERN     synchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   command can be accepted (idle)
//   cmd_steps   number of steps to move
//   cmd_dir     1 = forward, 0 = reverse
//   cmd_half    1 = half-step, 0 = full-step
//   step_div    step period minus one, in clk cycles
//   abort       stop the current move
//   hb_state    H-bridge phase drive
//   steps_left  steps remaining in the current move
//   dir         latched direction of the current/last move
//   busy        move in progress
//   done        one-cycle pulse at move end (normal, abort or zero-length)
module stepper_seq_driver #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned DIV_W     = 16,
    parameter bit          IDLE_HOLD = 1'b1
) (
    input  logic             clk,
    input  logic             PRESERN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             cmd_half,
    input  logic [DIV_W-1:0] step_div,
    input  logic             abort,
    output logic [3:0]       hb_state,
    output logic [CNT_W-1:0] steps_left,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [3:0]         hb_q, hb_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic               dir_q, dir_d;
    logic               half_q, half_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic               done_q, done_d;
    logic               energ_q, energ_d;

    logic [2:0]         adv;
    logic [2:0]         ptr_nx;

    function automatic logic [3:0] phase(input logic [2:0] idx);
        logic [3:0] p;
        case (idx)
            3'd0:    p = 4'b1001;
            3'd1:    p = 4'b0001;
            3'd2:    p = 4'b0101;
            3'd3:    p = 4'b0100;
            3'd4:    p = 4'b0110;
            3'd5:    p = 4'b0010;
            3'd6:    p = 4'b1010;
            default: p = 4'b1000;
        endcase
        return p;
    endfunction

    // An odd pointer only occurs in full-step mode on the first advance of a
    // move; stepping by one lands on the even (full-step) index.
    assign adv    = (half_q || ptr_q[0]) ? 3'd1 : 3'd2;
    assign ptr_nx = dir_q ? (ptr_q + adv) : (ptr_q - adv);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hb_d    = hb_q;
        steps_d = steps_q;
        dir_d   = dir_q;
        half_d  = half_q;
        div_d   = div_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        energ_d = energ_q;

        case (state_q)
            S_IDLE: begin
                if (IDLE_HOLD == 1'b0) begin
                    hb_d    = '0;
                    energ_d = 1'b0;
                end
                if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    half_d  = cmd_half;
                    div_d   = step_div;
                    presc_d = step_div;
                    steps_d = cmd_steps;
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    steps_d = '0;
                    done_d  = 1'b1;
                end else if (presc_q == '0) begin
                    presc_d = div_q;
                    // First tick after a de-energised idle only re-applies the
                    // stored phase; it still consumes a step.
                    if (energ_q) begin
                        ptr_d = ptr_nx;
                        hb_d  = phase(ptr_nx);
                    end else begin
                        energ_d = 1'b1;
                        hb_d    = phase(ptr_q);
                    end
                    if (steps_q != '0) begin
                        steps_d = steps_q - 1'b1;
                    end
                    if (steps_q <= CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!PRESERN) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            hb_q    <= '0;
            steps_q <= '0;
            dir_q   <= 1'b1;
            half_q  <= 1'b0;
            div_q   <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
            energ_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hb_q    <= hb_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            div_q   <= div_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            energ_q <= energ_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q == S_RUN);
    assign hb_state   = hb_q;
    assign steps_left = steps_q;
    assign dir        = dir_q;
    assign done       = done_q;

endmodule

// File: tb/tb_stepper_seq_driver.sv
// Testbench for stepper_seq_driver: one instance with IDLE_HOLD=1 and one
// with IDLE_HOLD=0 share the same stimulus; both are compared each cycle
// against a move-level reference model, plus directed table and sequences.
module tb_stepper_seq_driver;

    localparam int CW = 32;
    localparam int DW = 16;
    localparam logic [3:0] TAB [8] = '{4'b1001, 4'b0001, 4'b0101, 4'b0100,
                                       4'b0110, 4'b0010, 4'b1010, 4'b1000};

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid, cmd_dir, cmd_half, abort_i;
    logic [CW-1:0] cmd_steps;
    logic [DW-1:0] step_div;

    logic          rdy_h, dir_h, busy_h, done_h;
    logic [3:0]    hb_h;
    logic [CW-1:0] sl_h;
    logic          rdy_c, dir_c, busy_c, done_c;
    logic [3:0]    hb_c;
    logic [CW-1:0] sl_c;

    always #5 clk = ~clk;

    stepper_seq_driver #(.CNT_W(CW), .DIV_W(DW), .IDLE_HOLD(1'b1)) dut_h (
        .clk(clk), .PRESERN(rstn), .cmd_valid(cmd_valid), .cmd_ready(rdy_h),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half),
        .step_div(step_div), .abort(abort_i), .hb_state(hb_h),
        .steps_left(sl_h), .dir(dir_h), .busy(busy_h), .done(done_h)
    );

    stepper_seq_driver #(.CNT_W(CW), .DIV_W(DW), .IDLE_HOLD(1'b0)) dut_c (
        .clk(clk), .PRESERN(rstn), .cmd_valid(cmd_valid), .cmd_ready(rdy_c),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half),
        .step_div(step_div), .abort(abort_i), .hb_state(hb_c),
        .steps_left(sl_c), .dir(dir_c), .busy(busy_c), .done(done_c)
    );

    int errors = 0;
    int checks = 0;
    bit mchk   = 1'b1;

    // Move-level reference: position index, elapsed edges since accept.
    typedef struct {
        bit          busy;
        bit          energ;
        int          ptr;
        logic [3:0]  hb;
        int unsigned sl;
        bit          dir;
        bit          half;
        int unsigned div;
        int unsigned n;
        bit          done;
    } mdl_t;

    mdl_t mh, mc;

    function automatic mdl_t mstep(mdl_t m, bit hold);
        mdl_t r;
        int d;
        r = m;
        r.done = 1'b0;
        if (!rstn) begin
            r.busy = 0; r.energ = 0; r.ptr = 0; r.hb = 4'b0000; r.sl = 0;
            r.dir = 1; r.half = 0; r.div = 0; r.n = 0;
            return r;
        end
        if (m.busy) begin
            if (abort_i) begin
                r.busy = 0; r.sl = 0; r.done = 1;
            end else begin
                r.n = m.n + 1;
                if (r.n % (m.div + 1) == 0) begin
                    if (!m.energ) begin
                        r.energ = 1;
                    end else begin
                        d = (m.half || (m.ptr % 2 == 1)) ? 1 : 2;
                        r.ptr = (m.ptr + (m.dir ? d : 8 - d)) % 8;
                    end
                    r.hb = TAB[r.ptr];
                    r.sl = m.sl - 1;
                    if (r.sl == 0) begin
                        r.busy = 0; r.done = 1;
                    end
                end
            end
        end else begin
            if (!hold) begin
                r.hb = 4'b0000; r.energ = 0;
            end
            if (cmd_valid) begin
                r.dir = cmd_dir; r.half = cmd_half; r.div = step_div;
                r.sl = cmd_steps; r.n = 0;
                if (cmd_steps == 0) r.done = 1;
                else r.busy = 1;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        mh <= mstep(mh, 1'b1);
        mc <= mstep(mc, 1'b0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("m_hb_h",   32'(hb_h),   32'(mh.hb));
        chk("m_sl_h",   sl_h,        mh.sl);
        chk("m_dir_h",  32'(dir_h),  32'(mh.dir));
        chk("m_busy_h", 32'(busy_h), 32'(mh.busy));
        chk("m_rdy_h",  32'(rdy_h),  32'(!mh.busy));
        chk("m_done_h", 32'(done_h), 32'(mh.done));
        chk("m_hb_c",   32'(hb_c),   32'(mc.hb));
        chk("m_sl_c",   sl_c,        mc.sl);
        chk("m_busy_c", 32'(busy_c), 32'(mc.busy));
        chk("m_done_c", 32'(done_c), 32'(mc.done));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (mchk) cmp_model();
    endtask

    task automatic drv(input bit v, input int unsigned s, input bit d, input bit h,
                       input int unsigned dv, input bit ab);
        cmd_valid = v;
        cmd_steps = CW'(s);
        cmd_dir   = d;
        cmd_half  = h;
        step_div  = DW'(dv);
        abort_i   = ab;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hb_h"},   32'(hb_h),   32'h0);
        chk({tag, "_hb_c"},   32'(hb_c),   32'h0);
        chk({tag, "_rdy"},    32'(rdy_h),  32'h1);
        chk({tag, "_busy"},   32'(busy_h), 32'h0);
        chk({tag, "_done"},   32'(done_h), 32'h0);
        chk({tag, "_dir"},    32'(dir_h),  32'h1);
        chk({tag, "_sl"},     sl_h,        32'h0);
    endtask

    typedef struct {
        bit          v;
        int unsigned s;
        bit          d;
        bit          h;
        int unsigned dv;
        logic [3:0]  hbh;
        logic [3:0]  hbc;
        bit          busy;
        bit          done;
        int unsigned sl;
    } vec_t;

    vec_t tv [24];

    initial begin
        // fwd full div0, 3 steps from reset
        tv[0]  = '{1, 3, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, 3};
        tv[1]  = '{0, 0, 0, 0, 0, 4'b1001, 4'b1001, 1, 0, 2};
        tv[2]  = '{0, 0, 0, 0, 0, 4'b0101, 4'b0101, 1, 0, 1};
        tv[3]  = '{0, 0, 0, 0, 0, 4'b0110, 4'b0110, 0, 1, 0};
        tv[4]  = '{0, 0, 0, 0, 0, 4'b0110, 4'b0000, 0, 0, 0};
        // rev half div2, 4 steps
        tv[5]  = '{1, 4, 0, 1, 2, 4'b0110, 4'b0000, 1, 0, 4};
        tv[6]  = '{0, 0, 0, 0, 0, 4'b0110, 4'b0000, 1, 0, 4};
        tv[7]  = '{0, 0, 0, 0, 0, 4'b0110, 4'b0000, 1, 0, 4};
        tv[8]  = '{0, 0, 0, 0, 0, 4'b0100, 4'b0110, 1, 0, 3};
        tv[9]  = '{0, 0, 0, 0, 0, 4'b0100, 4'b0110, 1, 0, 3};
        tv[10] = '{0, 0, 0, 0, 0, 4'b0100, 4'b0110, 1, 0, 3};
        tv[11] = '{0, 0, 0, 0, 0, 4'b0101, 4'b0100, 1, 0, 2};
        tv[12] = '{0, 0, 0, 0, 0, 4'b0101, 4'b0100, 1, 0, 2};
        tv[13] = '{0, 0, 0, 0, 0, 4'b0101, 4'b0100, 1, 0, 2};
        tv[14] = '{0, 0, 0, 0, 0, 4'b0001, 4'b0101, 1, 0, 1};
        tv[15] = '{0, 0, 0, 0, 0, 4'b0001, 4'b0101, 1, 0, 1};
        tv[16] = '{0, 0, 0, 0, 0, 4'b0001, 4'b0101, 1, 0, 1};
        tv[17] = '{0, 0, 0, 0, 0, 4'b1001, 4'b0001, 0, 1, 0};
        // one half step fwd to reach ptr 1
        tv[18] = '{1, 1, 1, 1, 0, 4'b1001, 4'b0000, 1, 0, 1};
        tv[19] = '{0, 0, 0, 0, 0, 4'b0001, 4'b0001, 0, 1, 0};
        // fwd full from odd ptr: realign then full step
        tv[20] = '{1, 2, 1, 0, 0, 4'b0001, 4'b0000, 1, 0, 2};
        tv[21] = '{0, 0, 0, 0, 0, 4'b0101, 4'b0001, 1, 0, 1};
        tv[22] = '{0, 0, 0, 0, 0, 4'b0110, 4'b0101, 0, 1, 0};
        tv[23] = '{0, 0, 0, 0, 0, 4'b0110, 4'b0000, 0, 0, 0};

        rstn = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_reset("rst");
        rstn = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drv(tv[i].v, tv[i].s, tv[i].d, tv[i].h, tv[i].dv, 0);
            tick();
            chk($sformatf("tv%0d_hb_h", i), 32'(hb_h),   32'(tv[i].hbh));
            chk($sformatf("tv%0d_hb_c", i), 32'(hb_c),   32'(tv[i].hbc));
            chk($sformatf("tv%0d_busy", i), 32'(busy_h), 32'(tv[i].busy));
            chk($sformatf("tv%0d_rdy", i),  32'(rdy_c),  32'(!tv[i].busy));
            chk($sformatf("tv%0d_done", i), 32'(done_c), 32'(tv[i].done));
            chk($sformatf("tv%0d_sl", i),   sl_h,        tv[i].sl);
        end

        // Abort after the second phase change of a 10-step div4 move.
        drv(1, 10, 1, 0, 4, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("ab_ph1_h", 32'(hb_h), 32'(4'b1010));
        chk("ab_ph1_c", 32'(hb_c), 32'(4'b0101));
        for (int i = 0; i < 5; i++) tick();
        chk("ab_ph2_h", 32'(hb_h), 32'(4'b1001));
        chk("ab_ph2_c", 32'(hb_c), 32'(4'b0110));
        chk("ab_sl8",   sl_h,      32'd8);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("ab_busy", 32'(busy_h), 32'h0);
        chk("ab_sl",   sl_h,        32'h0);
        chk("ab_done", 32'(done_h), 32'h1);
        chk("ab_hb_h", 32'(hb_h),   32'(4'b1001));
        chk("ab_hb_c", 32'(hb_c),   32'(4'b0110));
        tick();
        chk("ab_done2",  32'(done_h), 32'h0);
        chk("ab_coast",  32'(hb_c),   32'h0);
        for (int i = 0; i < 6; i++) tick();
        chk("ab_hold",   32'(hb_h),   32'(4'b1001));
        chk("ab_done3",  32'(done_c), 32'h0);

        // Abort landing on a tick edge: abort wins, no phase change.
        drv(1, 5, 1, 1, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 1);
        tick();
        abort_i = 1'b0;
        chk("abt_hb_h", 32'(hb_h),   32'(4'b1001));
        chk("abt_hb_c", 32'(hb_c),   32'h0);
        chk("abt_done", 32'(done_h), 32'h1);
        chk("abt_sl",   sl_c,        32'h0);
        tick();

        // Zero-length command, abort held high in idle is ignored.
        drv(1, 0, 0, 1, 3, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        chk("z_busy", 32'(busy_h), 32'h0);
        chk("z_done", 32'(done_h), 32'h1);
        chk("z_hb",   32'(hb_h),   32'(4'b1001));
        chk("z_dir",  32'(dir_h),  32'h0);
        tick();
        chk("z_done2", 32'(done_h), 32'h0);

        // Reset while running.
        drv(1, 5, 0, 1, 1, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("rr_busy_pre", 32'(busy_h), 32'h1);
        rstn = 1'b0;
        tick();
        chk_reset("rr");
        rstn = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drv($urandom_range(0, 2) == 0, $urandom_range(0, 6), 1'($urandom),
                1'($urandom), $urandom_range(0, 3), $urandom_range(0, 19) == 0);
            rstn = ($urandom_range(0, 249) != 0);
            tick();
        end
        rstn = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
